ctrl_multiciclo: RTL

//  Multicycle main control FSM of the MIPS core; upstream end of the ALU-control interface.

---
 rtl/ctrl_multiciclo_pkg.sv | 109 ++++++++++
 rtl/ctrl_multiciclo_if.sv | 32 +++
 rtl/ctrl_multiciclo_saidas.sv | 85 ++++++++
 rtl/ctrl_multiciclo.sv | 81 ++++++++
 4 files changed

// File: rtl/ctrl_multiciclo_pkg.sv
// ctrl_multiciclo_pkg: state encodings, opcodes, ALUOp and mux-select codes for the multicycle control FSM
package ctrl_multiciclo_pkg;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_JR      = 4'd4,
        S_RWB     = 4'd5,
        S_MEMADDR = 4'd6,
        S_MEMRD   = 4'd7,
        S_MEMWB   = 4'd8,
        S_MEMWR   = 4'd9,
        S_BRANCH  = 4'd10,
        S_EXEC_I  = 4'd11,
        S_IWB     = 4'd12,
        S_JUMP    = 4'd13,
        S_JAL     = 4'd14,
        S_EXC     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_FUNCT = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_A      = 2'b11;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       alu_src_a;
        logic       epc_write;
        logic [1:0] alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
    } ctrl_t;

    // Undefined opcodes fall back to a NOP fetch unless the exception path is built in.
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:                   return S_EXEC_R;
            OP_LW, OP_SW:               return S_MEMADDR;
            OP_BEQ, OP_BNE:             return S_BRANCH;
            OP_J:                       return S_JUMP;
            OP_JAL:                     return S_JAL;
            OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_SLTI, OP_SLTIU: return S_EXEC_I;
`ifdef CTRL_EXC_EN
            default:                    return S_EXC;
`else
            default:                    return S_FETCH;
`endif
        endcase
    endfunction

    function automatic logic [2:0] alu_imm(input logic [5:0] op);
        case (op)
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            default:  return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_multiciclo_if.sv
// ctrl_multiciclo_if: control-unit <-> datapath bundle (opcode/flags in, enables/selects out)
interface ctrl_multiciclo_if;
    logic [5:0] opcode;
    logic       Jr;
    logic       Zero;
    logic       Overflow;
    logic [2:0] ALUOp;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] PCSource;
    logic       EPCWrite;

    modport master (
        input  opcode, Jr, Zero, Overflow,
        output ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource, EPCWrite
    );

    modport slave (
        output opcode, Jr, Zero, Overflow,
        input  ALUOp, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               ALUSrcA, ALUSrcB, RegDst, MemtoReg, PCSource, EPCWrite
    );
endinterface

// File: rtl/ctrl_multiciclo_saidas.sv
// ctrl_multiciclo_saidas: state -> control word decode (opcode only for EXEC_I ALUOp and branch sense)
import ctrl_multiciclo_pkg::*;

module ctrl_multiciclo_saidas (
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_last,
    output ctrl_t      o_ctrl
);

    // Per-state control word; PC/IR loads in FETCH wait for the final memory cycle.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_4;
                o_ctrl.ir_write  = i_last;
                o_ctrl.pc_write  = i_last;
            end
            S_DECODE:  o_ctrl.alu_src_b = SRCB_IMM2;
            S_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_JR: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_A;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = DST_RD;
            end
            S_MEMADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_SUB;
                o_ctrl.pc_source = PCS_ALUOUT;
                o_ctrl.pc_write  = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
            end
            S_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = alu_imm(i_opcode);
            end
            S_IWB:     o_ctrl.reg_write = 1'b1;
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JUMP;
            end
            S_JAL: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.reg_dst    = DST_RA;
                o_ctrl.mem_to_reg = M2R_PC;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.pc_source  = PCS_JUMP;
            end
`ifdef CTRL_EXC_EN
            S_EXC: begin
                o_ctrl.epc_write = 1'b1;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JUMP;
            end
`endif
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/ctrl_multiciclo.sv
// ctrl_multiciclo: multicycle MIPS main control FSM; optional exception path via CTRL_EXC_EN
import ctrl_multiciclo_pkg::*;

module ctrl_multiciclo #(
    parameter int MEM_WAIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    ctrl_multiciclo_if.master   bus
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_wait;
    logic       w_last;
    logic       w_ovf;
    ctrl_t      w_ctrl;

    assign w_last = (r_wait == 3'd0);

`ifdef CTRL_EXC_EN
    // The ALU only flags overflow for the signed (trapping) funct codes, so R-type needs no funct check.
    assign w_ovf = bus.Overflow;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = bus.Overflow;
    assign w_ovf = 1'b0;
`endif

    // State register and memory wait counter; counter reloads on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next == r_state) ? r_wait - 3'd1 : WAIT_LOAD;
        end
    end

    // Next-state logic; memory states hold until the wait counter expires.
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_RST:     w_next = S_FETCH;
            S_FETCH:   w_next = w_last ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = dispatch(bus.opcode);
            S_EXEC_R:  w_next = bus.Jr ? S_JR : (w_ovf ? S_EXC : S_RWB);
            S_MEMADDR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = w_last ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = w_last ? S_FETCH : S_MEMWR;
            S_EXEC_I:  w_next = (w_ovf && bus.opcode == OP_ADDI) ? S_EXC : S_IWB;
            default:   w_next = S_FETCH;
        endcase
    end

    ctrl_multiciclo_saidas u_saidas (
        .i_state  (r_state),
        .i_opcode (bus.opcode),
        .i_zero   (bus.Zero),
        .i_last   (w_last),
        .o_ctrl   (w_ctrl)
    );

    assign bus.ALUOp    = w_ctrl.alu_op;
    assign bus.PCWrite  = w_ctrl.pc_write;
    assign bus.IorD     = w_ctrl.i_or_d;
    assign bus.MemRead  = w_ctrl.mem_read;
    assign bus.MemWrite = w_ctrl.mem_write;
    assign bus.IRWrite  = w_ctrl.ir_write;
    assign bus.RegWrite = w_ctrl.reg_write;
    assign bus.ALUSrcA  = w_ctrl.alu_src_a;
    assign bus.ALUSrcB  = w_ctrl.alu_src_b;
    assign bus.RegDst   = w_ctrl.reg_dst;
    assign bus.MemtoReg = w_ctrl.mem_to_reg;
    assign bus.PCSource = w_ctrl.pc_source;
    assign bus.EPCWrite = w_ctrl.epc_write;

endmodule
